gray_counter: RTL and testbench

Parametrised up/down counter that keeps a binary count and a registered Gray-coded copy of it.
- Gray output changes exactly one bit per count step and is glitch-free, so it can be sampled by another clock domain (FIFO pointers, position encoders).
- Generalises the combinational binary-to-Gray converter: adds state, direction, load, enable and a boundary flag.

---
 rtl/gray_counter_pkg.sv | 25 ++
 rtl/bin2gray.sv | 19 +
 rtl/gray_counter.sv | 105 ++++++++++
 tb/tb_gray_counter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/gray_counter_pkg.sv
// gray_counter_pkg: shared definitions for the Gray-code counter slice.
//   bin_to_gray() : binary-to-Gray conversion (b ^ (b >> 1)), used by bin2gray
//                   and for the counter's reset constant.
//   max_count()   : all-ones value for a given width (2**width - 1).
//   step_op_e     : decoded per-cycle operation of the counter core.
// Helpers operate on 32-bit values; callers cast down to their own width.
package gray_counter_pkg;

   localparam int unsigned MAX_WIDTH = 32;

   typedef enum logic [1:0] {
      OpHold,
      OpCount,
      OpLoad
   } step_op_e;

   function automatic logic [MAX_WIDTH-1:0] bin_to_gray(input logic [MAX_WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [MAX_WIDTH-1:0] max_count(input int unsigned width);
      return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
   endfunction

endpackage

// File: rtl/bin2gray.sv
// bin2gray: combinational binary-to-Gray converter.
// Ports:
//   bin  - input  [WIDTH-1:0] binary value
//   gray - output [WIDTH-1:0] Gray code of bin
// WIDTH must not exceed gray_counter_pkg::MAX_WIDTH.
module bin2gray
   import gray_counter_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   always_comb begin
      gray = WIDTH'(bin_to_gray(MAX_WIDTH'(bin)));
   end

endmodule

// File: rtl/gray_counter.sv
// gray_counter: up/down binary counter with a registered Gray-coded copy.
// The Gray output comes straight from flip-flops, so during count steps it
// changes one bit per cycle and can be sampled safely from another clock domain.
// Ports:
//   clk        - input  clock, rising edge
//   srst       - input  synchronous reset, active-high (highest priority)
//   en         - input  count enable, one step per cycle
//   up         - input  direction: 1 = increment, 0 = decrement
//   load       - input  synchronous load (beats en)
//   load_value - input  [WIDTH-1:0] binary value to load
//   bin        - output [WIDTH-1:0] registered binary count
//   gray       - output [WIDTH-1:0] registered Gray code of bin
//   wrap       - output registered one-cycle wrap pulse
// Build option GRAY_COUNTER_SATURATE_EN: count steps at the limit hold the value
// and wrap becomes a saturation pulse instead of signalling a wrap-around.
module gray_counter
   import gray_counter_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned INIT  = 0
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(max_count(WIDTH));
   localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
   localparam logic [WIDTH-1:0] INIT_GRAY = WIDTH'(bin_to_gray(MAX_WIDTH'(INIT_BIN)));

   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             wrap_q, wrap_d;
   logic             at_limit;
   step_op_e         op;

   always_comb begin
      op = OpHold;
      if (load) begin
         op = OpLoad;
      end else if (en) begin
         op = OpCount;
      end
   end

   // The limit is the value from which the next step in the current direction
   // would cross the modulo boundary.
   always_comb begin
      at_limit = up ? (bin_q == MAX_COUNT) : (bin_q == '0);
   end

   always_comb begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
      unique case (op)
         OpLoad: begin
            bin_d = load_value;
         end
         OpCount: begin
`ifdef GRAY_COUNTER_SATURATE_EN
            if (!at_limit) begin
               bin_d = up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
            end
`else
            bin_d = up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
`endif
            wrap_d = at_limit;
         end
         default: begin
            bin_d = bin_q;
         end
      endcase
   end

   // Gray is derived from the next binary value so both registers update together.
   bin2gray #(
      .WIDTH (WIDTH)
   ) u_bin2gray (
      .bin  (bin_d),
      .gray (gray_d)
   );

   always_ff @(posedge clk) begin
      if (srst) begin
         bin_q  <= INIT_BIN;
         gray_q <= INIT_GRAY;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   assign bin  = bin_q;
   assign gray = gray_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed self-checking bench for gray_counter (WIDTH=4, INIT=0).
// Each step drives inputs, pushes the model's expected outputs to a scoreboard,
// then pops and compares after the clock edge.
module tb_gray_counter;

   localparam int unsigned WIDTH = 4;

   typedef struct {
      logic [WIDTH-1:0] bin;
      logic [WIDTH-1:0] gray;
      logic             wrap;
   } exp_t;

   logic             clk = 1'b0;
   logic             srst;
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] gray;
   logic             wrap;

   exp_t             sb[$];
   logic [WIDTH-1:0] gray_tbl [16];
   logic [WIDTH-1:0] mbin;
   logic [WIDTH-1:0] prev_gray;
   int               checks = 0;
   int               errors = 0;

   gray_counter #(
      .WIDTH (WIDTH),
      .INIT  (0)
   ) dut (
      .clk        (clk),
      .srst       (srst),
      .en         (en),
      .up         (up),
      .load       (load),
      .load_value (load_value),
      .bin        (bin),
      .gray       (gray),
      .wrap       (wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic s, input logic l,
                       input logic [WIDTH-1:0] lv, input logic e, input logic u);
      exp_t x;
      srst       = s;
      load       = l;
      load_value = lv;
      en         = e;
      up         = u;
      x.wrap     = 1'b0;
      if (s) begin
         mbin = '0;
      end else if (l) begin
         mbin = lv;
      end else if (e) begin
         if ((u && mbin == 4'd15) || (!u && mbin == 4'd0)) begin
            x.wrap = 1'b1;
`ifndef GRAY_COUNTER_SATURATE_EN
            mbin = u ? 4'd0 : 4'd15;
`endif
         end else begin
            mbin = u ? 4'(mbin + 4'd1) : 4'(mbin - 4'd1);
         end
      end
      x.bin  = mbin;
      x.gray = gray_tbl[mbin];
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      check({tag, ".bin"}, 32'(bin), 32'(x.bin));
      check({tag, ".gray"}, 32'(gray), 32'(x.gray));
      check({tag, ".wrap"}, 32'(wrap), 32'(x.wrap));
   endtask

   initial begin
      gray_tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                   4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
      mbin = '0;
      srst = 1'b0; load = 1'b0; load_value = '0; en = 1'b0; up = 1'b0;

      // Reset state
      step("reset", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

      // Full up sequence through the wrap, one gray bit per step
      prev_gray = gray;
      for (int i = 0; i < 16; i++) begin
         step("up_seq", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
         check("up_seq.onebit", 32'($countones(prev_gray ^ gray)), 32'd1);
         prev_gray = gray;
      end
      step("up_after_wrap", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);

      // Count down from reset: wraps to 15 then 14
      step("reset2", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      step("down_wrap", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      step("down_14", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);

      // Load beats en, then an up step
      step("load9", 1'b0, 1'b1, 4'd9, 1'b1, 1'b1);
      step("up_10", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);

      // Hold with up toggling, then direction flip with no bubble
      step("load6", 1'b0, 1'b1, 4'd6, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step("hold", 1'b0, 1'b0, 4'd3, 1'b0, 1'(i % 2));
      end
      step("flip_7", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      step("flip_8", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      step("flip_back7", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);

      // Reset overrides a simultaneous load and en
      step("load4", 1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
      step("up_5", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      step("srst_over_load", 1'b1, 1'b1, 4'd12, 1'b1, 1'b1);
      step("resume_1", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);

`ifdef GRAY_COUNTER_SATURATE_EN
      step("sat_load15", 1'b0, 1'b1, 4'd15, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step("sat_up", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      end
      step("sat_load0", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step("sat_down", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
